// File: rtl/palette_loader_if.sv
// palette_loader_if: HPS ioctl download bus as seen by the palette loader.
//   download  1   download window active
//   index     8   file type of the current download
//   wr        1   one-cycle strobe, addr/dout valid
//   addr      25  byte address within the file
//   dout      8   file byte
//   master: hps_io side (drives the bus); slave: palette_loader side.
interface palette_loader_if;
    logic        download;
    logic [7:0]  index;
    logic        wr;
    logic [24:0] addr;
    logic [7:0]  dout;
    modport master (output download, index, wr, addr, dout);
    modport slave  (input  download, index, wr, addr, dout);
endinterface

// File: rtl/palette_loader.sv
// palette_loader: parses a streamed RGB888 .pal file into RGB555 palette RAM writes.
//   clk               in   system clock
//   reset             in   synchronous, active-high
//   ioctl             in   palette_loader_if.slave download bus
//   load_color        out  one-cycle palette RAM write strobe
//   load_color_index  out  entry being written (held until the next write)
//   load_color_data   out  {B[7:3],G[7:3],R[7:3]} (held until the next write)
//   pal_loaded        out  last palette download delivered all ENTRIES entries
//   busy              out  palette download in progress
module palette_loader #(
    parameter logic [7:0] PAL_INDEX = 8'd2,
    parameter int         ENTRIES   = 64
) (
    input  logic              clk,
    input  logic              reset,
    palette_loader_if.slave   ioctl,
    output logic              load_color,
    output logic [5:0]        load_color_index,
    output logic [14:0]       load_color_data,
    output logic              pal_loaded,
    output logic              busy
);
    localparam int BYTES = ENTRIES * 3;

    typedef enum logic [1:0] {IDLE, GET_R, GET_G, GET_B} state_t;

    state_t     state, state_n, cur;
    logic       sel, sel_q, rise, fall, acc, restart, wr_entry;
    logic [6:0] cnt, cnt_cur;
    logic [4:0] r, g;
    logic       unused_low_bits;

    assign unused_low_bits = ^ioctl.dout[2:0];

    assign sel     = ioctl.download && (ioctl.index == PAL_INDEX);
    assign acc     = sel && ioctl.wr && (ioctl.addr < 25'(BYTES));
    // sel_q resets low, so a window already open at reset release counts as a rising edge
    assign rise    = sel && !sel_q;
    assign fall    = !sel && sel_q;
    // Start of a window, or a re-sent file (address 0), resynchronises to entry 0 red
    assign restart = rise || (acc && ioctl.addr == '0);
    assign busy    = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        cur      = restart ? GET_R : state;
        cnt_cur  = restart ? 7'd0 : cnt;
        wr_entry = acc && (cur == GET_B) && (cnt_cur < 7'(ENTRIES));
        state_n  = cur;
        if (fall)
            state_n = IDLE;
        else if (acc)
            state_n = (cur == GET_R) ? GET_G :
                      (cur == GET_G) ? GET_B :
                      (cur == GET_B) ? GET_R : IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sel_q            <= 1'b0;
            cnt              <= '0;
            r                <= '0;
            g                <= '0;
            load_color       <= 1'b0;
            load_color_index <= '0;
            load_color_data  <= '0;
            pal_loaded       <= 1'b0;
        end else begin
            sel_q      <= sel;
            load_color <= wr_entry;
            cnt        <= wr_entry ? cnt_cur + 7'd1 : cnt_cur;
            if (acc && cur == GET_R) r <= ioctl.dout[7:3];
            if (acc && cur == GET_G) g <= ioctl.dout[7:3];
            if (wr_entry) begin
                load_color_index <= cnt_cur[5:0];
                load_color_data  <= {ioctl.dout[7:3], g, r};
            end
            // A trailing partial entry never reaches cnt, so it cannot count toward a full palette
            if (rise)
                pal_loaded <= 1'b0;
            else if (fall)
                pal_loaded <= (cnt == 7'(ENTRIES));
        end
    end
endmodule

// File: tb/tb_palette_loader.sv
// tb_palette_loader: randomized self-checking bench for palette_loader against a file-level model.
module tb_palette_loader;
    localparam logic [7:0] PAL = 8'd2;

    typedef struct {
        int idx;
        int data;
        int cyc;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_color;
    logic [5:0]  load_color_index;
    logic [14:0] load_color_data;
    logic        pal_loaded;
    logic        busy;

    palette_loader_if ioctl ();

    palette_loader #(.PAL_INDEX(PAL), .ENTRIES(64)) dut (
        .clk              (clk),
        .reset            (reset),
        .ioctl            (ioctl.slave),
        .load_color       (load_color),
        .load_color_index (load_color_index),
        .load_color_data  (load_color_data),
        .pal_loaded       (pal_loaded),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    int         cyc = 0;
    int         vectors = 0;
    int         errors = 0;
    int         dbl = 0;
    logic       prev = 1'b0;
    logic       exp_loaded = 1'b0;
    logic [7:0] fb [0:1535];
    wr_t        exp_q[$];
    wr_t        got_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (load_color) begin
            got_q.push_back('{int'(load_color_index), int'(load_color_data), cyc});
            if (prev) dbl++;
        end
        prev = load_color;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < 1536; i++) fb[i] = 8'($urandom);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        ioctl.wr = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        exp_loaded = 1'b0;
    endtask

    // Streams a file; pre>0 first sends bytes 0..pre-1 then restarts at address 0 in the same window.
    // Returns right after byte abort_at when abort_at>=0, leaving the window open.
    task automatic send(input int len, input logic [7:0] idx, input int gap_max,
                        input int pre, input int abort_at);
        logic is_pal;
        int   n;
        is_pal = (idx == PAL);
        @(negedge clk);
        ioctl.download = 1'b1;
        ioctl.index    = idx;
        @(negedge clk);
        check("busy_start", 32'(busy), 32'(is_pal));
        for (int p = 0; p < 2; p++) begin
            n = (p == 0) ? pre : len;
            for (int a = 0; a < n; a++) begin
                ioctl.wr   = 1'b1;
                ioctl.addr = 25'(a);
                ioctl.dout = fb[a];
                if (is_pal && a < 192 && a % 3 == 2)
                    exp_q.push_back('{a / 3,
                        (int'(fb[a] >> 3) << 10) | (int'(fb[a-1] >> 3) << 5) | int'(fb[a-2] >> 3),
                        cyc + 1});
                @(negedge clk);
                ioctl.wr = 1'b0;
                if (a == abort_at) return;
                repeat ($urandom_range(gap_max, 0)) @(negedge clk);
            end
        end
        ioctl.download = 1'b0;
        repeat (3) @(negedge clk);
        if (is_pal) exp_loaded = (len >= 192);
        check("busy_end", 32'(busy), 32'd0);
        check("pal_loaded", 32'(pal_loaded), 32'(exp_loaded));
    endtask

    task automatic compare_writes(input string tag);
        check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        foreach (exp_q[i]) begin
            if (i < got_q.size()) begin
                check({tag, "_idx"},  32'(got_q[i].idx),  32'(exp_q[i].idx));
                check({tag, "_data"}, 32'(got_q[i].data), 32'(exp_q[i].data));
                check({tag, "_cyc"},  32'(got_q[i].cyc),  32'(exp_q[i].cyc));
            end
        end
        check({tag, "_double_pulse"}, 32'(dbl), 32'd0);
        got_q.delete();
        exp_q.delete();
        dbl = 0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_lc"},     32'(load_color),       32'd0);
        check({tag, "_index"},  32'(load_color_index), 32'd0);
        check({tag, "_data"},   32'(load_color_data),  32'd0);
        check({tag, "_loaded"}, 32'(pal_loaded),       32'd0);
        check({tag, "_busy"},   32'(busy),             32'd0);
    endtask

    initial begin
        reset          = 1'b1;
        ioctl.download = 1'b0;
        ioctl.index    = 8'd0;
        ioctl.wr       = 1'b0;
        ioctl.addr     = '0;
        ioctl.dout     = '0;
        do_reset();
        @(negedge clk);
        check_outputs_zero("reset");

        fill_random();
        fb[0] = 8'hFF; fb[1] = 8'h00; fb[2] = 8'h00;
        fb[189] = 8'h00; fb[190] = 8'h00; fb[191] = 8'hF8;
        send(192, PAL, 2, 0, -1);
        if (got_q.size() == 64) begin
            check("full_idx0_data",  32'(got_q[0].data),  32'h001F);
            check("full_idx63_data", 32'(got_q[63].data), 32'h7C00);
        end
        compare_writes("full");

        fill_random();
        fb[0] = 8'h7F; fb[1] = 8'h80; fb[2] = 8'h07;
        send(192, PAL, 0, 0, -1);
        if (got_q.size() > 0) check("trunc_idx0_data", 32'(got_q[0].data), 32'h020F);
        compare_writes("b2b");

        fill_random();
        send(1536, PAL, 1, 0, -1);
        compare_writes("long");

        fill_random();
        send(100, PAL, 1, 0, -1);
        compare_writes("short");

        fill_random();
        send(192, PAL, 1, 0, -1);
        compare_writes("reload");
        send(192, PAL + 8'd1, 1, 0, -1);
        compare_writes("other_index");

        fill_random();
        send(192, PAL, 0, 30, -1);
        compare_writes("resync");

        fill_random();
        send(192, PAL, 1, 0, 50);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_outputs_zero("abort");
        ioctl.download = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        exp_loaded = 1'b0;
        compare_writes("aborted");
        fill_random();
        send(192, PAL, 2, 0, -1);
        compare_writes("after_abort");

        @(negedge clk);
        reset          = 1'b1;
        ioctl.download = 1'b1;
        ioctl.index    = PAL;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        exp_loaded = 1'b0;
        fill_random();
        send(192, PAL, 1, 0, -1);
        compare_writes("sel_at_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
